// File: rtl/param_modulo_counter_if.sv
// -----------------------------------------------------------------------------
// param_modulo_counter_if
// Bundles the control and status signals of param_modulo_counter.
//
// Signals (named from the counter's point of view):
//   en         count enable
//   up         direction, 1 = up, 0 = down
//   clear      synchronous clear to zero
//   load       synchronous load of load_value
//   load_value value for load (WIDTH bits)
//   mod_we     write strobe for mod_n
//   mod_n      new modulus (WIDTH+1 bits, so 2^WIDTH fits)
//   counter    current count
//   tc         combinational terminal count, feeds the en of a next stage
//   wrap       registered one-cycle pulse after a wrap
//   err        registered one-cycle pulse after a rejected load or mod write
//
// Modports: master drives the controls, slave is the counter itself.
// -----------------------------------------------------------------------------
interface param_modulo_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             mod_we;
   logic [WIDTH:0]   mod_n;
   logic [WIDTH-1:0] counter;
   logic             tc;
   logic             wrap;
   logic             err;

   modport master (
      output en, up, clear, load, load_value, mod_we, mod_n,
      input  counter, tc, wrap, err
   );

   modport slave (
      input  en, up, clear, load, load_value, mod_we, mod_n,
      output counter, tc, wrap, err
   );
endinterface

// File: rtl/param_modulo_counter.sv
// -----------------------------------------------------------------------------
// param_modulo_counter
// Modulo-N up/down counter with a runtime-programmable modulus, synchronous
// clear/load, count enable and terminal-count / wrap / error flags for
// cascading stages (tc of one stage drives en of the next).
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = reset asserted)
//   bus    param_modulo_counter_if slave modport (controls in, status out)
//
// Parameters:
//   WIDTH    counter width in bits (>= 2)
//   MODULUS  modulus after reset, 2 <= MODULUS <= 2^WIDTH
// -----------------------------------------------------------------------------
module param_modulo_counter #(
   parameter int WIDTH   = 8,
   parameter int MODULUS = 10
) (
   input logic                   clk,
   input logic                   reset,
   param_modulo_counter_if.slave bus
);

   localparam logic [WIDTH:0] MIN_MOD   = (WIDTH+1)'(2);
   localparam logic [WIDTH:0] MAX_MOD   = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH:0] RESET_MOD = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH:0]   mod_q, mod_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;

   logic [WIDTH:0]   lastWide;
   logic [WIDTH-1:0] lastValue;
   logic             atTop;
   logic             atBottom;
   logic             tcRaw;
   logic             stepAllowed;

   // Comparisons run at WIDTH+1 bits so that a modulus of 2^WIDTH gives an
   // all-ones last value and the up-wrap is just the natural overflow.
   always_comb begin
      lastWide  = mod_q - (WIDTH+1)'(1);
      lastValue = lastWide[WIDTH-1:0];
      atTop     = ({1'b0, count_q} == lastWide);
      atBottom  = (count_q == '0);
      tcRaw     = bus.en & ((bus.up & atTop) | (~bus.up & atBottom));
   end

   // A count step only happens when no higher-priority request is present,
   // so tc is gated the same way to keep cascaded stages from stepping on a
   // cycle where this stage did not actually move.
   always_comb begin
      stepAllowed = ~bus.clear & ~bus.mod_we & ~bus.load;
      bus.tc      = tcRaw & stepAllowed;
   end

   // Next-state logic in priority order: clear, modulus write, load, count.
   always_comb begin
      count_d = count_q;
      mod_d   = mod_q;
      wrap_d  = 1'b0;
      err_d   = 1'b0;
      if (bus.clear) begin
         count_d = '0;
      end else if (bus.mod_we) begin
         if ((bus.mod_n >= MIN_MOD) && (bus.mod_n <= MAX_MOD)) begin
            mod_d   = bus.mod_n;
            count_d = '0;
         end else begin
            err_d = 1'b1;
         end
      end else if (bus.load) begin
         if ({1'b0, bus.load_value} < mod_q) begin
            count_d = bus.load_value;
         end else begin
            err_d = 1'b1;
         end
      end else if (bus.en) begin
         if (bus.up) begin
            count_d = atTop ? '0 : count_q + WIDTH'(1);
         end else begin
            count_d = atBottom ? lastValue : count_q - WIDTH'(1);
         end
         wrap_d = tcRaw;
      end
   end

   // State registers; reset restores the parameter modulus.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         mod_q   <= RESET_MOD;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         mod_q   <= mod_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      bus.counter = count_q;
      bus.wrap    = wrap_q;
      bus.err     = err_q;
   end

endmodule

// File: tb/tb_param_modulo_counter.sv
// -----------------------------------------------------------------------------
// tb_param_modulo_counter
// Directed bench for param_modulo_counter (WIDTH = 8, MODULUS = 10) plus a
// second cascaded stage whose en is the first stage's tc.
// -----------------------------------------------------------------------------
module tb_param_modulo_counter;

   logic clk;
   logic reset;
   int   checkCount;
   int   errorCount;
   int   wrapCount;

   param_modulo_counter_if #(.WIDTH(8)) mIf ();
   param_modulo_counter_if #(.WIDTH(8)) sIf ();

   param_modulo_counter #(.WIDTH(8), .MODULUS(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mIf)
   );

   param_modulo_counter #(.WIDTH(8), .MODULUS(10)) stage1 (
      .clk   (clk),
      .reset (reset),
      .bus   (sIf)
   );

   // The second stage only advances when the first one is at its terminal count.
   assign sIf.en = mIf.tc;

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expected value and logs mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drives every control input of the main counter at once.
   task automatic applyStimulus(input logic en, input logic up, input logic clear,
                                input logic load, input logic [7:0] loadValue,
                                input logic modWe, input logic [8:0] modN);
      mIf.en         = en;
      mIf.up         = up;
      mIf.clear      = clear;
      mIf.load       = load;
      mIf.load_value = loadValue;
      mIf.mod_we     = modWe;
      mIf.mod_n      = modN;
   endtask

   // Advances one clock and settles just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      wrapCount  = 0;
      reset      = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 9'd0);
      sIf.up         = 1'b1;
      sIf.clear      = 1'b0;
      sIf.load       = 1'b0;
      sIf.load_value = 8'd0;
      sIf.mod_we     = 1'b0;
      sIf.mod_n      = 9'd0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset counter", mIf.counter, 0);
      checkOutput("reset wrap", mIf.wrap, 0);
      checkOutput("reset err", mIf.err, 0);
      checkOutput("reset tc", mIf.tc, 0);
      reset = 1'b1;

      // Up count through one full period of 10
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 9'd0);
      for (int i = 1; i <= 9; i++) begin
         step();
         checkOutput($sformatf("up count %0d", i), mIf.counter, i);
         checkOutput($sformatf("up tc %0d", i), mIf.tc, (i == 9) ? 1 : 0);
         checkOutput($sformatf("up wrap %0d", i), mIf.wrap, 0);
      end
      step();
      checkOutput("up wrap counter", mIf.counter, 0);
      checkOutput("up wrap pulse", mIf.wrap, 1);
      step();
      checkOutput("up after wrap", mIf.counter, 1);
      checkOutput("up wrap cleared", mIf.wrap, 0);

      // Asynchronous reset in mid-cycle
      #3;
      reset = 1'b0;
      #1;
      checkOutput("async reset counter", mIf.counter, 0);
      #1;
      reset = 1'b1;

      // Down count from 0
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 9'd0);
      step();
      checkOutput("down wrap counter", mIf.counter, 9);
      checkOutput("down wrap pulse", mIf.wrap, 1);
      for (int i = 8; i >= 0; i--) begin
         step();
         checkOutput($sformatf("down count %0d", i), mIf.counter, i);
         checkOutput($sformatf("down tc %0d", i), mIf.tc, (i == 0) ? 1 : 0);
      end
      step();
      checkOutput("down rewrap counter", mIf.counter, 9);
      checkOutput("down rewrap pulse", mIf.wrap, 1);

      // Runtime modulus 4; tc is masked while mod_we is high
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 9'd4);
      #1;
      checkOutput("tc masked by mod_we", mIf.tc, 0);
      step();
      checkOutput("mod4 accept counter", mIf.counter, 0);
      checkOutput("mod4 accept err", mIf.err, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 9'd0);
      for (int i = 1; i <= 3; i++) begin
         step();
         checkOutput($sformatf("mod4 count %0d", i), mIf.counter, i);
      end
      checkOutput("mod4 tc", mIf.tc, 1);
      step();
      checkOutput("mod4 wrap counter", mIf.counter, 0);
      checkOutput("mod4 wrap pulse", mIf.wrap, 1);

      // Modulus 1 is rejected and modulus 4 stays active
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 9'd1);
      step();
      checkOutput("mod1 counter held", mIf.counter, 0);
      checkOutput("mod1 err", mIf.err, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 9'd0);
      step();
      checkOutput("mod1 err cleared", mIf.err, 0);
      checkOutput("mod1 count 1", mIf.counter, 1);
      repeat (3) step();
      checkOutput("mod still 4", mIf.counter, 0);

      // Full-range modulus 256
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 9'd256);
      step();
      checkOutput("mod256 accept counter", mIf.counter, 0);
      checkOutput("mod256 accept err", mIf.err, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 9'd0);
      repeat (255) step();
      checkOutput("mod256 top", mIf.counter, 255);
      checkOutput("mod256 tc", mIf.tc, 1);
      step();
      checkOutput("mod256 wrap counter", mIf.counter, 0);
      checkOutput("mod256 wrap pulse", mIf.wrap, 1);
      step();
      checkOutput("mod256 count 1", mIf.counter, 1);

      // Modulus 257 exceeds 2^WIDTH and is rejected
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 9'd257);
      step();
      checkOutput("mod257 counter held", mIf.counter, 1);
      checkOutput("mod257 err", mIf.err, 1);

      // Back to modulus 10, then load priority and range checks
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 9'd10);
      step();
      checkOutput("mod10 accept counter", mIf.counter, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 9'd0);
      step();
      checkOutput("load 3 over en", mIf.counter, 3);
      checkOutput("load 3 err", mIf.err, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd12, 1'b0, 9'd0);
      step();
      checkOutput("load 12 counter held", mIf.counter, 3);
      checkOutput("load 12 err", mIf.err, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd9, 1'b0, 9'd0);
      step();
      checkOutput("load 9 counter", mIf.counter, 9);
      checkOutput("load 9 err", mIf.err, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd10, 1'b0, 9'd0);
      step();
      checkOutput("load 10 counter held", mIf.counter, 9);
      checkOutput("load 10 err", mIf.err, 1);

      // Clear beats load and mod_we; tc masked while clear is high
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 9'd4);
      #1;
      checkOutput("tc masked by clear", mIf.tc, 0);
      step();
      checkOutput("clear counter", mIf.counter, 0);
      checkOutput("clear err", mIf.err, 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'd6, 1'b0, 9'd0);
      step();
      checkOutput("load 6 after clear", mIf.counter, 6);
      checkOutput("mod 10 kept after clear", mIf.err, 0);

      // Hold with en low
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 9'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput($sformatf("hold counter %0d", i), mIf.counter, 6);
         checkOutput($sformatf("hold tc %0d", i), mIf.tc, 0);
         checkOutput($sformatf("hold wrap %0d", i), mIf.wrap, 0);
      end

      // Cascade of two modulo-10 stages
      reset = 1'b0;
      #1;
      checkOutput("cascade reset stage0", mIf.counter, 0);
      checkOutput("cascade reset stage1", sIf.counter, 0);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 9'd0);
      for (int i = 1; i <= 100; i++) begin
         step();
         if (sIf.wrap) wrapCount++;
         if (i == 10) begin
            checkOutput("cascade stage0 at 10", mIf.counter, 0);
            checkOutput("cascade stage1 at 10", sIf.counter, 1);
         end
         if (i == 55) begin
            checkOutput("cascade stage0 at 55", mIf.counter, 5);
            checkOutput("cascade stage1 at 55", sIf.counter, 5);
         end
      end
      checkOutput("cascade stage0 at 100", mIf.counter, 0);
      checkOutput("cascade stage1 at 100", sIf.counter, 0);
      checkOutput("cascade stage1 wraps", wrapCount, 1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/param_modulo_counter.md
# param_modulo_counter

Parametrised modulo-N up/down counter for the bit-counter library. It replaces the fixed 8-bit modulo-N counter. It adds configurable width, a runtime-programmable modulus, direction control, synchronous clear and load, count enable, and terminal-count/wrap flags for cascading. It is a standalone leaf block, intended as a time base and for chaining (tc of one stage drives en of the next).

## Interface
- WIDTH, 8, counter width in bits (>= 2)
- MODULUS, 10, modulus loaded at reset; must satisfy 2 <= MODULUS <= 2^WIDTH
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- en  input  1  count enable
- up  input  1  direction: 1 = count up, 0 = count down
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous load of load_value
- load_value  input  WIDTH  value for load
- mod_we  input  1  write strobe for mod_n
- mod_n  input  WIDTH+1  new modulus
- counter  output  WIDTH  current count, always in 0..active_mod-1
- tc  output  1  terminal count (combinational)
- wrap  output  1  registered one-cycle pulse after a wrap
- err  output  1  registered one-cycle pulse after a rejected load/mod write

## Operation
- Internal register active_mod (WIDTH+1 bits) holds the current modulus.
- Reset asserted (reset = 0), asynchronously:
  - counter = 0, active_mod = MODULUS, wrap = 0, err = 0.
- Per rising edge, priority highest first:
  1. clear = 1: counter <= 0. All other requests are ignored that cycle.
  2. mod_we = 1:
     - If 2 <= mod_n <= 2^WIDTH: active_mod <= mod_n and counter <= 0.
     - Otherwise: no change, err pulses.
     - load and en are ignored that cycle.
  3. load = 1:
     - If load_value < active_mod: counter <= load_value.
     - Otherwise: counter unchanged, err pulses.
     - en is ignored that cycle.
  4. en = 1, up = 1: counter == active_mod-1 ? 0 : counter+1.
  5. en = 1, up = 0: counter == 0 ? active_mod-1 : counter-1.
  6. Otherwise: hold.
- Arithmetic:
  - Comparisons are done at WIDTH+1 bits.
  - With active_mod = 2^WIDTH, active_mod-1 is all ones and wrap is natural overflow.
  - The counter never leaves 0..active_mod-1.
- tc = en & ((up & counter == active_mod-1) | (~up & counter == 0)).
  - Combinational; stays 0 whenever clear, mod_we or load is asserted.
  - Intended as the en input of the next cascade stage.
- wrap <= 1 for exactly the cycle after an edge on which step 4 or 5 wrapped (the tc & step-taken condition); 0 otherwise.
- err <= 1 for exactly the cycle after a rejected mod_we or load; 0 otherwise.
- Flipping up mid-count takes effect on the next enabled edge; there is no pipeline.

## Timing
- Count latency: 1 clock from an en edge to the new counter value.
- clear, load and mod_we take effect on the same edge they are sampled.
- tc is valid in the same cycle as counter (combinational from registered counter plus inputs).
- wrap and err lag the causing edge by 1 cycle and are 1 cycle wide.
- Back-to-back wraps (e.g. modulus 2 with en held high) give a pulse on every wrapping edge; wrap may stay high on consecutive cycles.
- Asserting reset mid-count forces all outputs to reset values immediately, independent of clk.
- Release of reset is synchronised externally. The first count happens on the first rising edge with reset = 1 and en = 1.

## Test plan
- Reset/default count: reset = 0 for 2 cycles, then en = 1, up = 1 with WIDTH = 8, MODULUS = 10 -> counter 0,1,…,9,0. tc = 1 while counter = 9. wrap = 1 in the cycle counter first shows 0. Mid-count reset = 0 -> counter = 0 asynchronously.
- Down count: up = 0 from 0 -> counter 9,8,…,0,9. tc = 1 at counter 0. wrap pulses after 0→9.
- Runtime modulus: mod_we with mod_n = 4 -> counter = 0, then counts 0,1,2,3,0. mod_n = 1 -> err pulse, modulus stays 4. mod_n = 256 -> counter reaches 255 then wraps to 0.
- Load/clear priority: load_value = 3 with load = 1 and en = 1 -> counter = 3 (no increment). load_value = 12 with modulus 10 -> counter unchanged, err = 1 one cycle later. clear = 1 with load = 1 -> counter = 0.
- Enable/hold: en = 0 for 5 cycles at counter = 6 -> counter stays 6, tc = 0, wrap = 0.
- Cascade: two instances, MODULUS = 10 each, stage0 tc driving stage1 en -> after 100 enabled cycles both counters read 0. stage1 wrap pulses once.
